// File: rtl/grid_cursor_ctrl.sv
// Cursor controller for the board display: debounced Next/Prev/Select buttons
// move a cursor over a column-major ROWS x COLS grid, skipping occupied cells.
module grid_cursor_ctrl #(
    parameter int ROWS            = 3,
    parameter int COLS            = 3,
    parameter int H_RES           = 640,
    parameter int V_RES           = 480,
    parameter int DEBOUNCE_CYCLES = 250000,
    localparam int N              = ROWS * COLS,
    localparam int IDX_W          = (N > 1) ? $clog2(N) : 1
) (
    input  logic             Clk,
    input  logic             rst,
    input  logic             BtnNext,
    input  logic             BtnPrev,
    input  logic             BtnSel,
    input  logic [N-1:0]     occupied_mask,
    output logic [IDX_W-1:0] cursor_index,
    output logic [15:0]      selected_square_startX,
    output logic [15:0]      selected_square_endX,
    output logic [9:0]       selected_square_startY,
    output logic [9:0]       selected_square_endY,
    output logic             sel_valid,
    output logic [IDX_W-1:0] sel_index,
    output logic             sel_reject,
    output logic             busy
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int B_NEXT = 0;
    localparam int B_PREV = 1;
    localparam int B_SEL  = 2;

    typedef enum logic {IDLE, SEARCH} state_t;

    function automatic logic [15:0] x_edge(input int c);
        return 16'(c * H_RES / COLS);
    endfunction

    function automatic logic [9:0] y_edge(input int r);
        return 10'(r * V_RES / ROWS);
    endfunction

    logic [2:0]       raw;
    logic [2:0]       sync_p0;
    logic [2:0]       sync_p1;
    logic [2:0]       deb;
    logic [2:0]       deb_q;
    logic [2:0]       press;
    logic [CNT_W-1:0] cnt [3];

    assign raw = {BtnSel, BtnPrev, BtnNext};

    // Synchroniser, debounce counter and rising-edge press detector
    always_ff @(posedge Clk) begin
        if (!rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            deb     <= '0;
            deb_q   <= '0;
            press   <= '0;
            for (int b = 0; b < 3; b++) cnt[b] <= '0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            deb_q   <= deb;
            press   <= deb & ~deb_q;
            for (int b = 0; b < 3; b++) begin
                if (sync_p1[b] == deb[b]) begin
                    cnt[b] <= '0;
                end else if (cnt[b] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    cnt[b] <= '0;
                    deb[b] <= ~deb[b];
                end else begin
                    cnt[b] <= cnt[b] + 1'b1;
                end
            end
        end
    end

    state_t           state, state_n;
    logic [IDX_W-1:0] cand, cand_n, cand_step;
    logic             dir_neg, dir_neg_n;
    logic [IDX_W-1:0] cursor_n, sel_index_n;
    logic             sel_valid_n, sel_reject_n;

    always_comb begin
        if (dir_neg) cand_step = (cand == '0) ? IDX_W'(N - 1) : cand - 1'b1;
        else         cand_step = (cand == IDX_W'(N - 1)) ? '0 : cand + 1'b1;
    end

    always_comb begin
        state_n      = state;
        cand_n       = cand;
        dir_neg_n    = dir_neg;
        cursor_n     = cursor_index;
        sel_index_n  = sel_index;
        sel_valid_n  = 1'b0;
        sel_reject_n = 1'b0;
        case (state)
            IDLE: begin
                // Select wins over any simultaneous Next/Prev
                if (press[B_SEL]) begin
                    if (!occupied_mask[cursor_index]) begin
                        sel_valid_n = 1'b1;
                        sel_index_n = cursor_index;
                    end else begin
                        sel_reject_n = 1'b1;
                    end
                end else if (press[B_NEXT] ^ press[B_PREV]) begin
                    state_n   = SEARCH;
                    cand_n    = cursor_index;
                    dir_neg_n = press[B_PREV];
                end
            end
            SEARCH: begin
                if (cand_step == cursor_index) begin
                    state_n = IDLE;
                end else if (!occupied_mask[cand_step]) begin
                    cursor_n = cand_step;
                    state_n  = IDLE;
                end else begin
                    cand_n = cand_step;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!rst) begin
            state        <= IDLE;
            cursor_index <= '0;
            sel_index    <= '0;
            sel_valid    <= 1'b0;
            sel_reject   <= 1'b0;
        end else begin
            state        <= state_n;
            cursor_index <= cursor_n;
            sel_index    <= sel_index_n;
            sel_valid    <= sel_valid_n;
            sel_reject   <= sel_reject_n;
        end
    end

    always_ff @(posedge Clk) begin
        cand    <= cand_n;
        dir_neg <= dir_neg_n;
    end

    assign busy = (state == SEARCH);

    logic [15:0] sx_n, ex_n;
    logic [9:0]  sy_n, ey_n;

    // Constant per-cell table, indexed by the registered cursor
    always_comb begin
        sx_n = x_edge(0);
        ex_n = x_edge(1);
        sy_n = y_edge(0);
        ey_n = y_edge(1);
        for (int i = 0; i < N; i++) begin
            if (cursor_index == IDX_W'(i)) begin
                sx_n = x_edge(i / ROWS);
                ex_n = x_edge(i / ROWS + 1);
                sy_n = y_edge(i % ROWS);
                ey_n = y_edge(i % ROWS + 1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!rst) begin
            selected_square_startX <= x_edge(0);
            selected_square_endX   <= x_edge(1);
            selected_square_startY <= y_edge(0);
            selected_square_endY   <= y_edge(1);
        end else begin
            selected_square_startX <= sx_n;
            selected_square_endX   <= ex_n;
            selected_square_startY <= sy_n;
            selected_square_endY   <= ey_n;
        end
    end

endmodule
